// File: rtl/cnn_pkg.sv
// Shared CNN constants: default pixel width, feature-map side, pixel type and
// the upsampler state encoding.
package cnn_pkg;

  localparam int IN_D_W = 32;
  localparam int FMAP_W = 13;

  typedef logic signed [IN_D_W-1:0] pixel_t;

  typedef enum logic {
    S_FILL   = 1'b0,
    S_REPLAY = 1'b1
  } state_t;

  // Index width that stays legal for a depth of one.
  function automatic int idxWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/row_buf.sv
// One-row pixel store for the upsampler: a single write port and an
// asynchronous read port.
module row_buf
  import cnn_pkg::*;
#(
  parameter int DEPTH = FMAP_W,
  parameter int WIDTH = IN_D_W,
  localparam int AW   = idxWidth(DEPTH)
) (
  input  logic                    iClk,
  input  logic                    iWrEn,
  input  logic [AW-1:0]           iWrAddr,
  input  logic signed [WIDTH-1:0] iWrData,
  input  logic [AW-1:0]           iRdAddr,
  output logic signed [WIDTH-1:0] oRdData
);

  logic signed [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge iClk) begin
    if (iWrEn) mem[iWrAddr] <= iWrData;
  end

  assign oRdData = mem[iRdAddr];

endmodule

// File: rtl/upsample_2x.sv
// 2x upsampler with valid/ready on both sides; nearest-neighbour by default,
// zero-insertion when UPSAMPLE_ZERO_INSERT_EN is defined.
module upsample_2x
  import cnn_pkg::*;
#(
  parameter int In_d_W = IN_D_W,
  parameter int W_IN   = FMAP_W
) (
  input  logic                     iClk,
  input  logic                     iRsn,
  input  logic                     iInValid,
  input  logic signed [In_d_W-1:0] iInData,
  output logic                     oInReady,
  output logic                     oOutValid,
  output logic signed [In_d_W-1:0] oOutData,
  output logic                     oOutLast,
  input  logic                     iOutReady
);

  localparam int CW = idxWidth(W_IN);
  localparam logic [CW-1:0] LAST_IDX = CW'(W_IN - 1);

  state_t                   state, stateNext;
  logic [CW-1:0]            col, colNext;
  logic [CW-1:0]            row, rowNext;
  logic                     phase;
  logic                     heldLast;
  logic                     outFree;
  logic                     load;
  logic                     loadLast;
  logic signed [In_d_W-1:0] loadData;

  // The state flips as soon as the last column of a row is loaded, so the
  // next row's first pixel can be loaded on that pixel's second handshake.
  always_comb begin
    outFree   = !oOutValid || (iOutReady && phase);
    oInReady  = (state == S_FILL) && outFree;
    load      = outFree && ((state == S_REPLAY) || iInValid);
    loadLast  = load && (state == S_REPLAY) && (col == LAST_IDX) && (row == LAST_IDX);
    stateNext = state;
    colNext   = col;
    rowNext   = row;
    if (load) begin
      if (col == LAST_IDX) begin
        colNext   = '0;
        stateNext = (state == S_FILL) ? S_REPLAY : S_FILL;
        if (state == S_REPLAY) rowNext = (row == LAST_IDX) ? '0 : row + 1'b1;
      end else begin
        colNext = col + 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state <= S_FILL;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= stateNext;
      col   <= colNext;
      row   <= rowNext;
    end
  end

`ifdef UPSAMPLE_ZERO_INSERT_EN
  assign loadData = (state == S_FILL) ? iInData : '0;
`else
  logic signed [In_d_W-1:0] bufRdData;

  row_buf #(
    .DEPTH (W_IN),
    .WIDTH (In_d_W)
  ) uRowBuf (
    .iClk    (iClk),
    .iWrEn   (oInReady && iInValid),
    .iWrAddr (col),
    .iWrData (iInData),
    .iRdAddr (col),
    .oRdData (bufRdData)
  );

  assign loadData = (state == S_FILL) ? iInData : bufRdData;
`endif

  // Each loaded pixel is shown twice: phase 0 then phase 1.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      oOutValid <= 1'b0;
      oOutData  <= '0;
      oOutLast  <= 1'b0;
      phase     <= 1'b0;
      heldLast  <= 1'b0;
    end else if (load) begin
      oOutValid <= 1'b1;
      oOutData  <= loadData;
      oOutLast  <= 1'b0;
      phase     <= 1'b0;
      heldLast  <= loadLast;
    end else if (oOutValid && iOutReady) begin
      if (!phase) begin
        phase    <= 1'b1;
        oOutLast <= heldLast;
`ifdef UPSAMPLE_ZERO_INSERT_EN
        oOutData <= '0;
`endif
      end else begin
        oOutValid <= 1'b0;
        oOutLast  <= 1'b0;
        phase     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_upsample_2x.sv
// Bench for upsample_2x: a W_IN=2 and a W_IN=13 instance share one stimulus
// bus; a frame-index model checks both outputs every cycle.
module tb_upsample_2x;

  localparam int DW = 32;
  localparam int WA = 2;
  localparam int WB = 13;
`ifdef UPSAMPLE_ZERO_INSERT_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rsn;
  logic                 inValid;
  logic signed [DW-1:0] inData;
  logic                 outReady;
  logic                 inRdy  [2];
  logic                 outVal [2];
  logic                 outLst [2];
  logic signed [DW-1:0] outDat [2];

  upsample_2x #(.In_d_W(DW), .W_IN(WA)) dutA (
    .iClk(clk), .iRsn(rsn), .iInValid(inValid), .iInData(inData),
    .oInReady(inRdy[0]), .oOutValid(outVal[0]), .oOutData(outDat[0]),
    .oOutLast(outLst[0]), .iOutReady(outReady)
  );

  upsample_2x #(.In_d_W(DW), .W_IN(WB)) dutB (
    .iClk(clk), .iRsn(rsn), .iInValid(inValid), .iInData(inData),
    .oInReady(inRdy[1]), .oOutValid(outVal[1]), .oOutData(outDat[1]),
    .oOutLast(outLst[1]), .iOutReady(outReady)
  );

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Model state: accepted pixels per frame slot and transfer counters.
  int                   inTot [2];
  int                   outTot [2];
  logic signed [DW-1:0] store [2][WB*WB];
  bit                   prevStall [2];
  logic signed [DW-1:0] prevData [2];
  logic                 prevLast [2];
  int                   negCount = 0;
  logic signed [DW-1:0] capData0[$], capData1[$];
  bit                   capLast0[$], capLast1[$];
  int                   firstNeg [2], lastNeg [2], firstIn0, firstVal0;
  logic signed [DW-1:0] stimQ[$];

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      inTot[d] = 0; outTot[d] = 0; prevStall[d] = 0;
      firstNeg[d] = -1; lastNeg[d] = -1;
      for (int i = 0; i < WB*WB; i++) store[d][i] = '0;
    end
    firstIn0 = -1; firstVal0 = -1;
    capData0.delete(); capData1.delete(); capLast0.delete(); capLast1.delete();
  endtask

  // Output k of the stream is out[r][c] of frame k/(4W^2); input i must be
  // taken exactly when every output preceding its first copy has left.
  task automatic modelStep(input int d);
    int w, fs, k, kk, r, c, i, f;
    logic signed [DW-1:0] exp;
    w  = (d == 0) ? WA : WB;
    fs = 4 * w * w;
    if (prevStall[d]) begin
      checkOutput($sformatf("dut%0d_stall_valid", d), outVal[d], 1);
      checkOutput($sformatf("dut%0d_stall_data", d), outDat[d], prevData[d]);
      checkOutput($sformatf("dut%0d_stall_last", d), outLst[d], prevLast[d]);
    end
    if (outVal[d]) begin
      k   = outTot[d];
      kk  = k % fs;
      r   = kk / (2 * w);
      c   = kk % (2 * w);
      exp = store[d][(r / 2) * w + c / 2];
      if (ZERO && ((r % 2) != 0 || (c % 2) != 0)) exp = '0;
      checkOutput($sformatf("dut%0d_out%0d_data", d, k), outDat[d], exp);
      checkOutput($sformatf("dut%0d_out%0d_last", d, k), outLst[d], (kk == fs - 1) ? 1 : 0);
    end
    prevStall[d] = outVal[d] && !outReady;
    prevData[d]  = outDat[d];
    prevLast[d]  = outLst[d];
    if (outVal[d] && outReady) outTot[d]++;
    if (inValid && inRdy[d]) begin
      i = inTot[d] % (w * w);
      f = inTot[d] / (w * w);
      checkOutput($sformatf("dut%0d_in%0d_timing", d, inTot[d]), outTot[d],
                  f * fs + (i / w) * 4 * w + 2 * (i % w));
      store[d][i] = inData;
      inTot[d]++;
    end
  endtask

  // Mid-cycle sampling: model step plus capture of accepted outputs.
  always @(negedge clk) begin
    negCount++;
    if (rsn === 1'b1) begin
      modelStep(0);
      modelStep(1);
      if (inValid && inRdy[0] && firstIn0 < 0) firstIn0 = negCount;
      if (outVal[0] && firstVal0 < 0) firstVal0 = negCount;
      if (outVal[0] && outReady) begin
        capData0.push_back(outDat[0]); capLast0.push_back(outLst[0]);
        if (firstNeg[0] < 0) firstNeg[0] = negCount;
        lastNeg[0] = negCount;
      end
      if (outVal[1] && outReady) begin
        capData1.push_back(outDat[1]); capLast1.push_back(outLst[1]);
        if (firstNeg[1] < 0) firstNeg[1] = negCount;
        lastNeg[1] = negCount;
      end
    end
  end

  function automatic int capCount(input int sel);
    return (sel == 0) ? capData0.size() : capData1.size();
  endfunction

  // Present queued pixels, popping on handshakes with the selected instance.
  task automatic applyStimulus(input int sel, input int maxCycles, input bit toggle, input int untilOut);
    bit accepted = 0;
    bit done = 0;
    for (int n = 0; n < maxCycles; n++) begin
      @(posedge clk); #1;
      if (accepted) void'(stimQ.pop_front());
      if (stimQ.size() == 0 && capCount(sel) >= untilOut) begin
        done = 1;
        break;
      end
      outReady = toggle ? ~outReady : 1'b1;
      inValid  = (stimQ.size() > 0);
      inData   = inValid ? stimQ[0] : '0;
      @(negedge clk);
      accepted = inValid && inRdy[sel];
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    checkOutput("stimulus_done_in_budget", done, 1);
  endtask

  task automatic doReset();
    @(posedge clk); #2;
    inValid = 1'b0;
    rsn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("dut%0d_async_reset_valid", d), outVal[d], 0);
      checkOutput($sformatf("dut%0d_async_reset_data", d), outDat[d], 0);
      checkOutput($sformatf("dut%0d_async_reset_last", d), outLst[d], 0);
    end
    modelReset();
    stimQ.delete();
    @(posedge clk); #2;
    rsn = 1'b1;
  endtask

  int expSeq[16];
  int lastCnt;

  initial begin
    rsn = 1'b0; inValid = 1'b0; inData = '0; outReady = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #2 rsn = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("dut%0d_reset_valid", d), outVal[d], 0);
      checkOutput($sformatf("dut%0d_reset_inready", d), inRdy[d], 1);
      checkOutput($sformatf("dut%0d_reset_last", d), outLst[d], 0);
    end

    // W_IN=2 basic frame with downstream always ready
    doReset();
    stimQ = '{1, 2, 3, 4};
    applyStimulus(0, 100, 1'b0, 16);
    if (ZERO) expSeq = '{1,0,2,0,0,0,0,0,3,0,4,0,0,0,0,0};
    else      expSeq = '{1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4};
    checkOutput("basic_count", capData0.size(), 16);
    for (int i = 0; i < 16 && i < capData0.size(); i++) begin
      checkOutput($sformatf("basic_data%0d", i), capData0[i], expSeq[i]);
      checkOutput($sformatf("basic_last%0d", i), capLast0[i], (i == 15) ? 1 : 0);
    end
    checkOutput("basic_latency", firstVal0 - firstIn0, 1);
    checkOutput("basic_continuous", lastNeg[0] - firstNeg[0], 15);

    // Back-pressure with iOutReady toggling every cycle
    doReset();
    stimQ = '{10, 20, 30, 40};
    applyStimulus(0, 200, 1'b1, 16);
    if (ZERO) expSeq = '{10,0,20,0,0,0,0,0,30,0,40,0,0,0,0,0};
    else      expSeq = '{10,10,20,20,10,10,20,20,30,30,40,40,30,30,40,40};
    checkOutput("bp_count", capData0.size(), 16);
    for (int i = 0; i < 16 && i < capData0.size(); i++)
      checkOutput($sformatf("bp_data%0d", i), capData0[i], expSeq[i]);

    // Negative pixel keeps its sign in all four copies
    doReset();
    stimQ = '{-5, 1, 2, 3};
    applyStimulus(0, 100, 1'b0, 16);
    if (capData0.size() >= 6) begin
      checkOutput("neg_copy00", capData0[0], -5);
      checkOutput("neg_copy01", capData0[1], ZERO ? 0 : -5);
      checkOutput("neg_copy10", capData0[4], ZERO ? 0 : -5);
      checkOutput("neg_copy11", capData0[5], ZERO ? 0 : -5);
    end else begin
      checkOutput("neg_count", capData0.size(), 16);
    end

    // Reset in the middle of a W_IN=13 frame, then restart at pixel (0,0)
    doReset();
    for (int i = 0; i < 40; i++) stimQ.push_back(100 + i);
    applyStimulus(1, 1000, 1'b0, 0);
    doReset();
    stimQ = '{777, 778};
    applyStimulus(1, 100, 1'b0, 1);
    if (capData1.size() > 0) checkOutput("restart_first_pixel", capData1[0], 777);
    else                     checkOutput("restart_count", capData1.size(), 1);

    // Two back-to-back W_IN=13 frames, input always valid
    doReset();
    for (int i = 0; i < 2 * WB * WB; i++) stimQ.push_back(i * 7 - 1000);
    applyStimulus(1, 4000, 1'b0, 8 * WB * WB);
    checkOutput("frames_count", capData1.size(), 8 * WB * WB);
    lastCnt = 0;
    foreach (capLast1[i]) if (capLast1[i]) lastCnt++;
    checkOutput("frames_last_pulses", lastCnt, 2);
    if (capLast1.size() == 8 * WB * WB) begin
      checkOutput("frames_last_first", capLast1[4*WB*WB-1], 1);
      checkOutput("frames_last_second", capLast1[8*WB*WB-1], 1);
    end
    checkOutput("frames_continuous", lastNeg[1] - firstNeg[1], 8 * WB * WB - 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
